// File: rtl/data_memory_pipe.sv
// Word-addressed data RAM with byte enables, 1..4 cycle read pipeline, ready handshake and post-reset clearing.
// Optional per-byte even parity storage and checking is enabled by defining DMEM_PARITY_EN.
module data_memory_pipe #(
  parameter int unsigned WORD        = 16,
  parameter int unsigned ADDRESSL    = 10,
  parameter int unsigned LENGTH      = 1024,
  parameter int unsigned RD_LATENCY  = 1,
  parameter int unsigned WRITE_FIRST = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDRESSL-1:0]   address,
  input  logic [WORD-1:0]       writeData,
  input  logic [WORD/8-1:0]     byteEn,
  input  logic                  memWrite,
  input  logic                  memRead,
  output logic                  ready,
  output logic [WORD-1:0]       readData,
  output logic                  readValid,
  output logic                  parityErr
);

  localparam int unsigned NB   = WORD / 8;
  localparam int unsigned IDXW = (LENGTH > 1) ? $clog2(LENGTH) : 1;
  localparam int unsigned AW1  = ADDRESSL + 1;
  localparam logic [AW1-1:0]      LEN_X = AW1'(LENGTH);
  localparam logic [ADDRESSL-1:0] LAST  = ADDRESSL'(LENGTH - 1);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t              r_state, w_state_nxt;
  logic [ADDRESSL-1:0] r_cnt, w_cnt_nxt;
  logic                w_init_we;
  logic                w_ready;

  logic [WORD-1:0]     r_mem [LENGTH];
  logic [IDXW-1:0]     w_idx;
  logic [IDXW-1:0]     w_cnt_idx;
  logic                w_in_range;
  logic                w_acc_rd;
  logic                w_acc_wr;
  logic [WORD-1:0]     w_old;
  logic [WORD-1:0]     w_merged;
  logic [WORD-1:0]     w_rd_word;
  logic                w_rd_perr;

  logic [RD_LATENCY-1:0] r_pv;
  logic [RD_LATENCY-1:0] r_pe;
  logic [WORD-1:0]       r_pd [RD_LATENCY];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_INIT;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_init_we   = 1'b0;
    w_ready     = 1'b0;
    case (r_state)
      ST_INIT: begin
        w_init_we = 1'b1;
        w_cnt_nxt = r_cnt + 1'b1;
        if (r_cnt == LAST) begin
          w_state_nxt = ST_RUN;
          w_cnt_nxt   = '0;
        end
      end
      ST_RUN:  w_ready = 1'b1;
      default: w_state_nxt = ST_INIT;
    endcase
  end

  always_comb begin
    w_idx      = address[IDXW-1:0];
    w_cnt_idx  = r_cnt[IDXW-1:0];
    w_in_range = ({1'b0, address} < LEN_X);
    w_acc_rd   = w_ready & memRead;
    w_acc_wr   = w_ready & memWrite & w_in_range;
    w_old      = r_mem[w_idx];
    w_merged   = w_old;
    for (int unsigned b = 0; b < NB; b++) begin
      if (byteEn[b]) w_merged[8*b +: 8] = writeData[8*b +: 8];
    end
    // Write-first forwards the merged word; otherwise the pre-edge array contents are returned.
    if (!w_in_range)                     w_rd_word = '0;
    else if (WRITE_FIRST != 0 && w_acc_wr) w_rd_word = w_merged;
    else                                 w_rd_word = w_old;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (w_init_we) begin
        r_mem[w_cnt_idx] <= '0;
      end else if (w_acc_wr) begin
        for (int unsigned b = 0; b < NB; b++) begin
          if (byteEn[b]) r_mem[w_idx][8*b +: 8] <= writeData[8*b +: 8];
        end
      end
    end
  end

`ifdef DMEM_PARITY_EN
  logic [NB-1:0] r_par [LENGTH];
  logic [NB-1:0] w_par_rd;

  always_comb begin
    w_par_rd = r_par[w_idx];
    if (WRITE_FIRST != 0 && w_acc_wr) begin
      for (int unsigned b = 0; b < NB; b++) begin
        if (byteEn[b]) w_par_rd[b] = ^writeData[8*b +: 8];
      end
    end
    w_rd_perr = 1'b0;
    if (w_in_range) begin
      for (int unsigned b = 0; b < NB; b++) begin
        if ((^w_rd_word[8*b +: 8]) != w_par_rd[b]) w_rd_perr = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (w_init_we) begin
        r_par[w_cnt_idx] <= '0;
      end else if (w_acc_wr) begin
        for (int unsigned b = 0; b < NB; b++) begin
          if (byteEn[b]) r_par[w_idx][b] <= ^writeData[8*b +: 8];
        end
      end
    end
  end
`else
  always_comb w_rd_perr = 1'b0;
`endif

  // Each stage holds its data when no read passes through, so readData keeps its last value.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pv <= '0;
      r_pe <= '0;
      for (int unsigned k = 0; k < RD_LATENCY; k++) r_pd[k] <= '0;
    end else begin
      r_pv[0] <= w_acc_rd;
      if (w_acc_rd) begin
        r_pd[0] <= w_rd_word;
        r_pe[0] <= w_rd_perr;
      end
      for (int unsigned k = 1; k < RD_LATENCY; k++) begin
        r_pv[k] <= r_pv[k-1];
        if (r_pv[k-1]) begin
          r_pd[k] <= r_pd[k-1];
          r_pe[k] <= r_pe[k-1];
        end
      end
    end
  end

  assign ready     = w_ready;
  assign readValid = r_pv[RD_LATENCY-1];
  assign readData  = r_pd[RD_LATENCY-1];
  assign parityErr = r_pv[RD_LATENCY-1] & r_pe[RD_LATENCY-1];

endmodule

// File: tb/tb_data_memory_pipe.sv
// Self-checking bench for data_memory_pipe: directed vector table, corner sequences and a
// randomized run checked every cycle against a queue-based reference model.
module tb_data_memory_pipe;

  localparam int unsigned WORD = 16;
  localparam int unsigned AL   = 6;
  localparam int unsigned LEN  = 32;
  localparam int unsigned LAT  = 3;
  localparam int unsigned WF   = 0;

  logic            clk = 1'b0;
  logic            rst;
  logic [AL-1:0]   address;
  logic [15:0]     writeData;
  logic [1:0]      byteEn;
  logic            memWrite;
  logic            memRead;
  logic            ready;
  logic [15:0]     readData;
  logic            readValid;
  logic            parityErr;

  data_memory_pipe #(
    .WORD(WORD), .ADDRESSL(AL), .LENGTH(LEN), .RD_LATENCY(LAT), .WRITE_FIRST(WF)
  ) dut (
    .clk(clk), .rst(rst), .address(address), .writeData(writeData), .byteEn(byteEn),
    .memWrite(memWrite), .memRead(memRead), .ready(ready), .readData(readData),
    .readValid(readValid), .parityErr(parityErr)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [15:0] d;
    logic        pe;
  } pend_t;

  typedef struct {
    logic [AL-1:0] a;
    logic [15:0]   wd;
    logic [1:0]    be;
    logic [15:0]   exp;
  } vec_t;

  logic [15:0] m_mem [LEN];
  bit          m_bad [LEN];
  pend_t       q[$];
  logic [15:0] m_last;
  int          init_left = LEN;
  int          edge_no   = 0;
  int          n_pass    = 0;
  int          n_total   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at edge %0d", name, act, exp, edge_no);
  endtask

  // One clock edge: update the reference model from the sampled inputs, then check all outputs.
  task automatic step();
    bit          mready, inr, exp_v, exp_pe;
    logic [15:0] old, mrg;
    pend_t       p;
    mready = (init_left == 0);
    @(posedge clk);
    edge_no++;
    if (rst) begin
      init_left = LEN;
      q.delete();
      m_last = '0;
      for (int i = 0; i < int'(LEN); i++) begin
        m_mem[i] = '0;
        m_bad[i] = 1'b0;
      end
    end else begin
      if (init_left > 0) init_left--;
      if (mready && (memRead || memWrite)) begin
        inr = (int'(address) < int'(LEN));
        old = inr ? m_mem[int'(address)] : 16'h0;
        mrg = old;
        if (byteEn[0]) mrg[7:0]  = writeData[7:0];
        if (byteEn[1]) mrg[15:8] = writeData[15:8];
        if (memRead) begin
          p.due = edge_no + int'(LAT) - 1;
          p.d   = !inr ? 16'h0 : ((WF != 0 && memWrite) ? mrg : old);
          p.pe  = inr && m_bad[int'(address)] && !(WF != 0 && memWrite && byteEn[0]);
          q.push_back(p);
        end
        if (memWrite && inr) begin
          m_mem[int'(address)] = mrg;
          if (byteEn[0]) m_bad[int'(address)] = 1'b0;
        end
      end
    end
    #1;
    exp_v  = (q.size() > 0 && q[0].due == edge_no);
    exp_pe = 1'b0;
    if (exp_v) begin
      m_last = q[0].d;
      exp_pe = q[0].pe;
      void'(q.pop_front());
    end
    chk("ready", 32'(ready), 32'(init_left == 0));
    chk("readValid", 32'(readValid), 32'(exp_v));
    chk("readData", 32'(readData), 32'(m_last));
    chk("parityErr", 32'(parityErr), 32'(exp_pe));
  endtask

  task automatic idle();
    memRead = 1'b0; memWrite = 1'b0; rst = 1'b0;
    step();
  endtask

  task automatic wait_ready(output int n, output int pulses);
    n = 0; pulses = 0;
    memRead = 1'b0; memWrite = 1'b0; rst = 1'b0;
    while (!ready && n < int'(LEN) + 20) begin
      step();
      n++;
      if (readValid) pulses++;
    end
  endtask

  task automatic do_write(input logic [AL-1:0] a, input logic [15:0] d, input logic [1:0] be);
    address = a; writeData = d; byteEn = be; memWrite = 1'b1; memRead = 1'b0; rst = 1'b0;
    step();
    memWrite = 1'b0;
  endtask

  // Issues a read and returns the data plus the number of idle cycles until readValid.
  task automatic do_read(input logic [AL-1:0] a, output logic [15:0] d, output int k, output logic pe);
    address = a; memRead = 1'b1; memWrite = 1'b0; rst = 1'b0;
    step();
    memRead = 1'b0;
    k = 0;
    while (!readValid && k < 8) begin
      idle();
      k++;
    end
    d  = readData;
    pe = parityErr;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t        tv [8];
    int          n, pulses, k;
    logic [15:0] d;
    logic        pe;
    logic [15:0] got [2];

    tv[0] = '{6'd7,  16'h1234, 2'b11, 16'h1234};
    tv[1] = '{6'd7,  16'hAB00, 2'b10, 16'hAB34};
    tv[2] = '{6'd7,  16'hFFFF, 2'b00, 16'hAB34};
    tv[3] = '{6'd7,  16'h00CD, 2'b01, 16'hABCD};
    tv[4] = '{6'd10, 16'hBEEF, 2'b11, 16'hBEEF};
    tv[5] = '{6'd40, 16'h5555, 2'b11, 16'h0000};
    tv[6] = '{6'd31, 16'h0102, 2'b11, 16'h0102};
    tv[7] = '{6'd0,  16'hA5A5, 2'b01, 16'h00A5};

    rst = 1'b1; memRead = 1'b0; memWrite = 1'b0;
    address = '0; writeData = '0; byteEn = '0;
    step();
    step();
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_readData", 32'(readData), 32'd0);
    chk("rst_readValid", 32'(readValid), 32'd0);
    rst = 1'b0;
    wait_ready(n, pulses);
    chk("init_cycles", 32'(n), 32'(LEN));

    address = 6'd5; memRead = 1'b1;
    step();
    memRead = 1'b0;
    pulses = readValid ? 1 : 0;
    d = 16'hFFFF;
    if (readValid) d = readData;
    for (int i = 0; i < int'(LAT) + 3; i++) begin
      idle();
      if (readValid) begin
        pulses++;
        d = readData;
      end
    end
    chk("rd5_pulses", 32'(pulses), 32'd1);
    chk("rd5_data", 32'(d), 32'h0);

    for (int i = 0; i < 8; i++) begin
      do_write(tv[i].a, tv[i].wd, tv[i].be);
      do_read(tv[i].a, d, k, pe);
      chk("vec_data", 32'(d), 32'(tv[i].exp));
      chk("vec_latency", 32'(k), 32'(LAT - 1));
    end

    do_write(6'd3, 16'h1111, 2'b11);
    address = 6'd3; writeData = 16'h2222; byteEn = 2'b11; memWrite = 1'b1; memRead = 1'b1;
    n = 0;
    step();
    if (readValid && n < 2) begin got[n] = readData; n++; end
    memWrite = 1'b0;
    step();
    if (readValid && n < 2) begin got[n] = readData; n++; end
    memRead = 1'b0;
    for (int i = 0; i < int'(LAT) + 3; i++) begin
      idle();
      if (readValid && n < 2) begin got[n] = readData; n++; end
    end
    chk("rdw_count", 32'(n), 32'd2);
    if (n == 2) begin
      chk("rdw_same_cycle", 32'(got[0]), (WF != 0) ? 32'h2222 : 32'h1111);
      chk("rdw_next_cycle", 32'(got[1]), 32'h2222);
    end

    do_write(6'd1, 16'h0101, 2'b11);
    do_write(6'd2, 16'h0202, 2'b11);
    do_write(6'd3, 16'h0303, 2'b11);
    pulses = 0;
    for (int e = 0; e <= int'(LAT) + 1; e++) begin
      memRead = (e < 3);
      address = AL'(e + 1);
      rst = (e == int'(LAT) + 1);
      step();
      if (!rst && readValid) pulses++;
    end
    chk("midrst_pulses", 32'(pulses), 32'd2);
    chk("midrst_valid", 32'(readValid), 32'd0);
    chk("midrst_data", 32'(readData), 32'd0);
    rst = 1'b0; memRead = 1'b0;
    wait_ready(n, pulses);
    chk("midrst_init_cycles", 32'(n), 32'(LEN));
    chk("midrst_lost_read", 32'(pulses), 32'd0);
    do_read(6'd1, d, k, pe);
    chk("midrst_cleared", 32'(d), 32'h0);

`ifdef DMEM_PARITY_EN
    do_write(6'd4, 16'h00F0, 2'b11);
    idle();
    dut.r_par[4][0] = ~dut.r_par[4][0];
    m_bad[4] = 1'b1;
    do_read(6'd4, d, k, pe);
    chk("parity_flip", 32'(pe), 32'd1);
    chk("parity_flip_data", 32'(d), 32'h00F0);
    do_read(6'd5, d, k, pe);
    chk("parity_clean", 32'(pe), 32'd0);
    do_write(6'd4, 16'h0000, 2'b11);
`endif

    for (int i = 0; i < 800; i++) begin
      rst       = ($urandom_range(0, 399) == 0);
      memRead   = 1'($urandom);
      memWrite  = 1'($urandom);
      address   = AL'($urandom_range(0, LEN + 3));
      writeData = 16'($urandom);
      byteEn    = 2'($urandom);
      step();
    end
    for (int i = 0; i < int'(LAT) + 2; i++) idle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/data_memory_pipe.md
Name: data_memory_pipe

Overview:
Parametrised successor to the single-cycle data memory, used as the data-side RAM of the processor datapath. Word-addressed storage with per-byte write enables, configurable read latency (1-4 cycles), and a ready handshake. A post-reset clearing engine zeroes every location, so memory contents are deterministic after every reset, not only at power-up. Read-during-write ordering is selectable by parameter.

Parameters:
WORD, 16, data width in bits; multiple of 8
ADDRESSL, 10, address width in bits
LENGTH, 1024, number of words; must be ≤ 2**ADDRESSL
RD_LATENCY, 1, edges from request to data; legal range 1..4
WRITE_FIRST, 0, same-cycle read+write to one address: 0 returns old data, 1 returns new merged data

Ports:
clk  input  1  clock; all state changes on posedge
rst  input  1  synchronous, active-high reset
address  input  ADDRESSL  word address of the request
writeData  input  WORD  write data
byteEn  input  WORD/8  per-byte write enable; bit i covers writeData[8i+7:8i]
memWrite  input  1  write request
memRead  input  1  read request
ready  output  1  high when requests are accepted
readData  output  WORD  read result
readValid  output  1  one-cycle pulse marking new readData
parityErr  output  1  parity mismatch on current readData; present only with the optional feature

Behaviour:
- Reset: rst sampled high at a posedge sets readData=0, readValid=0, ready=0, parityErr=0, and clears all read-pipeline stages.
  - FSM goes to INIT and the clear counter goes to 0.
  - Reset mid-operation discards in-flight reads; readValid does not pulse for them.
- FSM states: INIT and RUN.
  - INIT: writes zero to memory[counter] on each edge, then increments the counter. After writing LENGTH-1, the next state is RUN.
  - INIT therefore lasts exactly LENGTH cycles after rst deasserts. ready=0 throughout.
  - RUN: ready=1. Remains in RUN until rst.
- Acceptance:
  - A request is accepted at posedge N if ready=1 and memRead or memWrite is high.
  - Requests with ready=0 are ignored: no write occurs and no readValid results.
  - There is no backpressure in RUN; one request per cycle is accepted indefinitely.
- Write: at edge N, each byte with byteEn set is updated. Bytes with byteEn clear are unchanged. A write with byteEn=0 is a no-op.
- Read latency:
  - readData is updated and readValid is high in the cycle following edge N+RD_LATENCY-1. With RD_LATENCY=1 this is the cycle right after the request edge.
  - readValid is a one-cycle pulse. Back-to-back reads give back-to-back pulses, in order.
  - readData holds its last value when readValid=0; it never returns to 0 except on reset.
- Read-during-write: memRead and memWrite together on the same address resolve per WRITE_FIRST.
  - WRITE_FIRST=1 returns the byte-merged new word.
  - A read at edge N+1 after a write at edge N always sees the new data, for either setting.
- Out-of-range address (address ≥ LENGTH): writes are dropped. Reads return 0 with a normal readValid pulse.
- Read pipeline stages are registers; the memory array is a single write port plus a synchronous read.

Optional Feature:
Macro DMEM_PARITY_EN.
- Defined:
  - One even-parity bit is stored per byte and written together with its byte. INIT writes parity 0.
  - On read, parity is recomputed per byte. parityErr is high, aligned with readValid, if any byte mismatches.
  - readData is still delivered unmodified.
- Undefined: no parity storage; the parityErr port is tied to 0.

Test Plan:
- Reset, then count cycles -> ready rises exactly LENGTH cycles after rst falls. A read of address 5 then returns 0x0000 with one readValid pulse.
- RD_LATENCY=3: write 0xBEEF to address 10 with byteEn=2'b11, read address 10 at edge N -> readData=0xBEEF and readValid high only in the cycle after edge N+2.
- Word 0x1234 at address 7: write 0xAB00 with byteEn=2'b10, then read -> 0xAB34. A write with byteEn=2'b00 leaves 0xAB34 unchanged.
- Address 3 holds 0x1111; same-cycle read+write of 0x2222 -> returns 0x1111 with WRITE_FIRST=0, 0x2222 with WRITE_FIRST=1. A read on the next cycle returns 0x2222 in both cases.
- Reads to addresses 1,2,3 issued back-to-back, then rst pulsed one cycle before the 3rd result -> the third readValid never appears, ready=0 for LENGTH cycles, and address 1 reads 0 afterwards.
- DMEM_PARITY_EN: bench backdoor-flips the stored parity bit of address 4 -> the read of address 4 shows parityErr=1 with readValid. An unflipped read shows parityErr=0.
